// File: rtl/sprite_sched_pkg.sv
// Shared types for the sprite command scheduler: FSM states, queue entry layout
// and the sprite action encodings also used by the decoder.
package sprite_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        WB      = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  action;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [4:0]  dst_reg;
    } sched_entry_t;

    localparam logic [3:0] SPR_ACT  = 4'h0;
    localparam logic [3:0] SPR_LD   = 4'h1;
    localparam logic [3:0] SPR_MAP  = 4'h2;
    localparam logic [3:0] SPR_TM   = 4'h3;
    localparam logic [3:0] SPR_RD   = 4'h4;
    localparam logic [3:0] SPR_CORD = 4'h5;

endpackage

// File: rtl/sched_fifo.sv
// In-order command queue. The head entry is visible combinationally so the
// scheduler can present it on the same cycle it decides to issue.
module sched_fifo
    import sprite_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  sched_entry_t             din,
    output sched_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    sched_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sprite_cmd_sched.sv
// Queues sprite commands from EX, issues them in order over req/ack, and writes
// read results back with a bounded wait for read data.
module sprite_cmd_sched
    import sprite_sched_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic        cmd_re,
    input  logic [3:0]  cmd_action,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [4:0]  cmd_dst_reg,
    output logic        stall,
    output logic        spr_req,
    output logic        spr_we,
    output logic [3:0]  spr_action,
    output logic [7:0]  spr_addr,
    output logic [31:0] spr_data,
    input  logic        spr_ack,
    input  logic        spr_rd_valid,
    input  logic [31:0] spr_rd_data,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        rd_err,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    sched_state_t   state_reg;
    sched_entry_t   head;
    sched_entry_t   new_entry;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           has_work;
    logic           tmo_hit;
    logic           rd_pending_reg;
    logic [TW-1:0]  tmo_cnt_reg;
    logic [31:0]    rd_data_reg;
    logic           rd_err_reg;

    assign new_entry = '{we: ~cmd_re, action: cmd_action, addr: cmd_addr,
                         data: cmd_data, dst_reg: cmd_dst_reg};

    assign push = cmd_valid & ~full & ~rd_pending_reg;
    assign pop  = ((state_reg == ISSUE) & spr_ack & head.we) | (state_reg == WB);

    sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (new_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Occupancy after this cycle's push/pop, so back-to-back commands keep ISSUE busy.
    always_comb begin
        count_next = count;
        if (push) begin
            count_next = count_next + CW'(1);
        end
        if (pop) begin
            count_next = count_next - CW'(1);
        end
    end

    assign has_work = (count_next != '0);
    // The counter is sampled before its increment, so fire one step early.
    assign tmo_hit  = (tmo_cnt_reg == TW'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rd_pending_reg <= 1'b0;
            tmo_cnt_reg    <= '0;
            rd_data_reg    <= '0;
            rd_err_reg     <= 1'b0;
        end else begin
            if (push && cmd_re) begin
                rd_pending_reg <= 1'b1;
            end else if (state_reg == WB) begin
                rd_pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (has_work) begin
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (spr_ack) begin
                        if (head.we) begin
                            state_reg <= has_work ? ISSUE : IDLE;
                        end else begin
                            state_reg   <= WAIT_RD;
                            tmo_cnt_reg <= '0;
                        end
                    end
                end
                WAIT_RD: begin
                    tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    if (spr_rd_valid) begin
                        rd_data_reg <= spr_rd_data;
                        state_reg   <= WB;
                    end else if (tmo_hit) begin
                        rd_data_reg <= '0;
                        rd_err_reg  <= 1'b1;
                        state_reg   <= WB;
                    end
                end
                WB: begin
                    state_reg <= has_work ? ISSUE : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign spr_req    = (state_reg == ISSUE);
    assign spr_we     = spr_req & head.we;
    assign spr_action = spr_req ? head.action : '0;
    assign spr_addr   = spr_req ? head.addr   : '0;
    assign spr_data   = spr_req ? head.data   : '0;

    assign wb_valid = (state_reg == WB);
    assign wb_reg   = wb_valid ? head.dst_reg : '0;
    assign wb_data  = wb_valid ? rd_data_reg  : '0;

    assign stall  = rd_pending_reg | (cmd_valid & full);
    assign rd_err = rd_err_reg;
    assign busy   = ~empty | (state_reg != IDLE);

endmodule

// File: tb/tb_sprite_cmd_sched.sv
// Directed bench for sprite_cmd_sched: writes, full queue, reads, timeout,
// read/timeout race and reset during an outstanding read.
module tb_sprite_cmd_sched;
    import sprite_sched_pkg::*;

    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_re;
    logic [3:0]  cmd_action;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [4:0]  cmd_dst_reg;
    logic        stall;
    logic        spr_req;
    logic        spr_we;
    logic [3:0]  spr_action;
    logic [7:0]  spr_addr;
    logic [31:0] spr_data;
    logic        spr_ack;
    logic        spr_rd_valid;
    logic [31:0] spr_rd_data;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        rd_err;
    logic        busy;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sprite_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_re       (cmd_re),
        .cmd_action   (cmd_action),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_dst_reg  (cmd_dst_reg),
        .stall        (stall),
        .spr_req      (spr_req),
        .spr_we       (spr_we),
        .spr_action   (spr_action),
        .spr_addr     (spr_addr),
        .spr_data     (spr_data),
        .spr_ack      (spr_ack),
        .spr_rd_valid (spr_rd_valid),
        .spr_rd_data  (spr_rd_data),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .rd_err       (rd_err),
        .busy         (busy)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && spr_req && spr_ack)
            $display("[TB] issue we=%0b act=%h addr=%h data=%h", spr_we, spr_action, spr_addr, spr_data);
        if (rst_n === 1'b1 && wb_valid)
            $display("[TB] writeback reg=%0d data=%h rd_err=%0b", wb_reg, wb_data, rd_err);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic [3:0] act, input logic [7:0] addr,
                         input logic [31:0] data, input logic [4:0] dst);
        cmd_valid   = 1'b1;
        cmd_re      = re;
        cmd_action  = act;
        cmd_addr    = addr;
        cmd_data    = data;
        cmd_dst_reg = dst;
    endtask

    task automatic idle_cmd();
        cmd_valid   = 1'b0;
        cmd_re      = 1'b0;
        cmd_action  = '0;
        cmd_addr    = '0;
        cmd_data    = '0;
        cmd_dst_reg = '0;
    endtask

    task automatic randomize_inputs();
        cmd_valid    = 1'($urandom);
        cmd_re       = 1'($urandom);
        cmd_action   = 4'($urandom);
        cmd_addr     = 8'($urandom);
        cmd_data     = $urandom;
        cmd_dst_reg  = 5'($urandom);
        spr_ack      = 1'($urandom);
        spr_rd_valid = 1'($urandom);
        spr_rd_data  = $urandom;
    endtask

    task automatic test_reset();
        logic [81:0] outs;
        rst_n = 1'b0;
        randomize_inputs();
        for (int c = 0; c < 2; c++) begin
            cyc();
            randomize_inputs();
        end
        #1;
        outs = {stall, spr_req, spr_we, spr_action, spr_addr, spr_data, wb_valid, wb_reg, rd_err};
        tests_run++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h exp 0", outs);
        end
        tests_run++;
        if (wb_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_wb_data: got %h exp 0", wb_data);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b exp 0", busy);
        end
        idle_cmd();
        spr_ack      = 1'b0;
        spr_rd_valid = 1'b0;
        spr_rd_data  = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_writes();
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
        spr_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1'b0, SPR_LD, 8'(5 + c), 32'hA000_0000 + 32'(c), 5'd0);
            else       idle_cmd();
            #1;
            if (c < 3) begin
                tests_run++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL wr_stall c%0d: got %b exp 0", c, stall);
                end
            end
            if (c >= 1 && c <= 3) begin
                exp_addr = 8'(4 + c);
                exp_data = 32'hA000_0000 + 32'(c - 1);
                tests_run++;
                if (spr_req !== 1'b1 || spr_we !== 1'b1 || spr_addr !== exp_addr || spr_data !== exp_data) begin
                    fails++;
                    $display("FAIL wr_issue c%0d: got req=%b we=%b addr=%h data=%h exp req=1 we=1 addr=%h data=%h",
                             c, spr_req, spr_we, spr_addr, spr_data, exp_addr, exp_data);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (busy !== 1'b0 || spr_req !== 1'b0) begin
                    fails++;
                    $display("FAIL wr_drain: got busy=%b req=%b exp 0 0", busy, spr_req);
                end
            end
            cyc();
        end
    endtask

    task automatic test_full();
        logic [7:0] exp_addr;
        for (int c = 0; c < 12; c++) begin
            spr_ack = (c >= 6);
            if (c < 4)      drive(1'b0, SPR_MAP, 8'(8'h20 + c), 32'(c), 5'd0);
            else if (c < 8) drive(1'b0, SPR_MAP, 8'h24, 32'd4, 5'd0);
            else            idle_cmd();
            #1;
            if (c < 4) begin
                tests_run++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL full_fill_stall c%0d: got %b exp 0", c, stall);
                end
            end
            if (c >= 4 && c <= 7) begin
                tests_run++;
                if (stall !== (c < 7)) begin
                    fails++;
                    $display("FAIL full_stall c%0d: got %b exp %b", c, stall, (c < 7));
                end
            end
            if (c >= 4 && c <= 10) begin
                exp_addr = (c <= 6) ? 8'h20 : 8'(8'h20 + c - 6);
                tests_run++;
                if (spr_req !== 1'b1 || spr_addr !== exp_addr) begin
                    fails++;
                    $display("FAIL full_order c%0d: got req=%b addr=%h exp req=1 addr=%h", c, spr_req, spr_addr, exp_addr);
                end
            end
            if (c == 11) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL full_drain: got busy=%b exp 0", busy);
                end
            end
            cyc();
        end
    endtask

    task automatic test_read();
        spr_ack = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 0)      drive(1'b1, SPR_RD, 8'h10, 32'h0, 5'd7);
            else if (c <= 6) drive(1'b0, SPR_TM, 8'h30, 32'h5555_AAAA, 5'd0);
            else             idle_cmd();
            spr_rd_valid = (c == 4);
            spr_rd_data  = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (c == 0 || c == 6) begin
                tests_run++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL rd_stall_low c%0d: got %b exp 0", c, stall);
                end
            end
            if (c >= 1 && c <= 5) begin
                tests_run++;
                if (stall !== 1'b1) begin
                    fails++;
                    $display("FAIL rd_stall_high c%0d: got %b exp 1", c, stall);
                end
            end
            if (c == 1) begin
                tests_run++;
                if (spr_req !== 1'b1 || spr_we !== 1'b0 || spr_addr !== 8'h10) begin
                    fails++;
                    $display("FAIL rd_issue: got req=%b we=%b addr=%h exp 1 0 10", spr_req, spr_we, spr_addr);
                end
            end
            if (c >= 2 && c <= 6 && c != 5) begin
                tests_run++;
                if (spr_req !== 1'b0 || wb_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rd_quiet c%0d: got req=%b wb=%b exp 0 0", c, spr_req, wb_valid);
                end
            end
            if (c == 5) begin
                tests_run++;
                if (wb_valid !== 1'b1 || wb_reg !== 5'd7 || wb_data !== 32'hDEAD_BEEF || spr_req !== 1'b0) begin
                    fails++;
                    $display("FAIL rd_wb: got wb=%b reg=%0d data=%h req=%b exp 1 7 deadbeef 0",
                             wb_valid, wb_reg, wb_data, spr_req);
                end
            end
            if (c == 7) begin
                tests_run++;
                if (spr_req !== 1'b1 || spr_we !== 1'b1 || spr_addr !== 8'h30) begin
                    fails++;
                    $display("FAIL rd_next_write: got req=%b we=%b addr=%h exp 1 1 30", spr_req, spr_we, spr_addr);
                end
            end
            if (c == 8) begin
                tests_run++;
                if (busy !== 1'b0 || rd_err !== 1'b0 || wb_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rd_end: got busy=%b rd_err=%b wb=%b exp 0 0 0", busy, rd_err, wb_valid);
                end
            end
            cyc();
        end
    endtask

    task automatic test_race();
        spr_ack = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 0) drive(1'b1, SPR_CORD, 8'h12, 32'h0, 5'd9);
            else        idle_cmd();
            spr_rd_valid = (c == 8);
            spr_rd_data  = (c == 8) ? 32'h1234_5678 : 32'h0;
            #1;
            if (c >= 2 && c <= 8) begin
                tests_run++;
                if (wb_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL race_early_wb c%0d: got %b exp 0", c, wb_valid);
                end
            end
            if (c == 9) begin
                tests_run++;
                if (wb_valid !== 1'b1 || wb_reg !== 5'd9 || wb_data !== 32'h1234_5678 || rd_err !== 1'b0) begin
                    fails++;
                    $display("FAIL race_wb: got wb=%b reg=%0d data=%h rd_err=%b exp 1 9 12345678 0",
                             wb_valid, wb_reg, wb_data, rd_err);
                end
            end
            if (c == 10) begin
                tests_run++;
                if (rd_err !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL race_end: got rd_err=%b busy=%b exp 0 0", rd_err, busy);
                end
            end
            cyc();
        end
    endtask

    task automatic test_timeout();
        spr_ack = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 0)       drive(1'b1, SPR_RD, 8'h11, 32'h0, 5'd3);
            else if (c == 11) drive(1'b1, SPR_RD, 8'h13, 32'h0, 5'd4);
            else              idle_cmd();
            spr_rd_valid = (c == 13);
            spr_rd_data  = (c == 13) ? 32'hCAFE_F00D : 32'h0;
            #1;
            if (c >= 2 && c <= 8) begin
                tests_run++;
                if (wb_valid !== 1'b0 || rd_err !== 1'b0) begin
                    fails++;
                    $display("FAIL tmo_wait c%0d: got wb=%b rd_err=%b exp 0 0", c, wb_valid, rd_err);
                end
            end
            if (c == 9) begin
                tests_run++;
                if (wb_valid !== 1'b1 || wb_reg !== 5'd3 || wb_data !== 32'h0 || rd_err !== 1'b1) begin
                    fails++;
                    $display("FAIL tmo_wb: got wb=%b reg=%0d data=%h rd_err=%b exp 1 3 0 1",
                             wb_valid, wb_reg, wb_data, rd_err);
                end
            end
            if (c == 10 || c == 15) begin
                tests_run++;
                if (rd_err !== 1'b1 || wb_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL tmo_sticky c%0d: got rd_err=%b wb=%b exp 1 0", c, rd_err, wb_valid);
                end
            end
            if (c == 14) begin
                tests_run++;
                if (wb_valid !== 1'b1 || wb_reg !== 5'd4 || wb_data !== 32'hCAFE_F00D || rd_err !== 1'b1) begin
                    fails++;
                    $display("FAIL tmo_next_read: got wb=%b reg=%0d data=%h rd_err=%b exp 1 4 cafef00d 1",
                             wb_valid, wb_reg, wb_data, rd_err);
                end
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid_read();
        spr_ack = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 0) drive(1'b1, SPR_RD, 8'h14, 32'h0, 5'd11);
            else        idle_cmd();
            rst_n        = !(c == 3 || c == 4);
            spr_rd_valid = (c == 7);
            spr_rd_data  = (c == 7) ? 32'hBAD0_BAD0 : 32'h0;
            #1;
            if (c == 2) begin
                tests_run++;
                if (busy !== 1'b1 || stall !== 1'b1 || rd_err !== 1'b1) begin
                    fails++;
                    $display("FAIL rst_pre: got busy=%b stall=%b rd_err=%b exp 1 1 1", busy, stall, rd_err);
                end
            end
            if (c >= 5) begin
                tests_run++;
                if (wb_valid !== 1'b0 || spr_req !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_post c%0d: got wb=%b req=%b busy=%b stall=%b exp 0 0 0 0",
                             c, wb_valid, spr_req, busy, stall);
                end
            end
            if (c == 10) begin
                tests_run++;
                if (rd_err !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_rd_err: got %b exp 0", rd_err);
                end
            end
            cyc();
        end
        spr_rd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_writes();
        test_full();
        test_read();
        test_race();
        test_timeout();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
